// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed access latency,
// byte/half/word/double loads and stores with misalignment and range checks.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic            clk,
  input logic            rst_n,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic          w_exec;
  logic          w_misalign;
  logic          w_oor;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [5:0]    w_sh;
  logic [63:0]   w_word;
  logic [63:0]   w_lane;
  logic [63:0]   w_shifted;
  logic [63:0]   w_load;
  logic [63:0]   w_newword;

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  // The access executes on the edge that moves WAIT into RESP.
  assign w_exec = (r_state == WAIT) && (r_cnt == '0);

  // Decode the latched request: error check, lane selection, load extraction, store merge.
  always_comb begin
    w_misalign = 1'b0;
    unique case (r_size)
      2'b00: w_misalign = 1'b0;
      2'b01: w_misalign = r_addr[0];
      2'b10: w_misalign = (r_addr[1:0] != 2'b00);
      2'b11: w_misalign = (r_addr[2:0] != 3'b000);
    endcase
    w_oor  = (r_addr >> 3) >= 64'(DEPTH_WORDS);
    w_err  = w_misalign || w_oor;
    w_idx  = r_addr[AW+2:3];
    w_sh   = {r_addr[2:0], 3'b000};
    w_word = r_mem[w_idx];

    w_lane = '1;
    unique case (r_size)
      2'b00: w_lane = 64'h0000_0000_0000_00FF;
      2'b01: w_lane = 64'h0000_0000_0000_FFFF;
      2'b10: w_lane = 64'h0000_0000_FFFF_FFFF;
      2'b11: w_lane = '1;
    endcase

    w_shifted = w_word >> w_sh;
    w_load    = w_shifted;
    unique case (r_size)
      2'b00: w_load = r_unsigned ? {56'd0, w_shifted[7:0]}
                                 : {{56{w_shifted[7]}}, w_shifted[7:0]};
      2'b01: w_load = r_unsigned ? {48'd0, w_shifted[15:0]}
                                 : {{48{w_shifted[15]}}, w_shifted[15:0]};
      2'b10: w_load = r_unsigned ? {32'd0, w_shifted[31:0]}
                                 : {{32{w_shifted[31]}}, w_shifted[31:0]};
      2'b11: w_load = w_shifted;
    endcase

    w_newword = (w_word & ~(w_lane << w_sh)) | ((r_wdata & w_lane) << w_sh);
  end

  // Storage is never reset; a store commits only on a clean execute edge.
  always_ff @(posedge clk) begin
    if (rst_n && w_exec && r_write && !w_err) begin
      r_mem[w_idx] <= w_newword;
    end
  end

  // Request/latency/response state machine with registered response outputs.
  // The counter is loaded with LATENCY-1 and RESP is entered on the edge after
  // it reaches zero, so LATENCY==1 passes through WAIT for a single edge and
  // every latency setting raises resp_valid exactly LATENCY edges after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_cnt      <= 4'(LATENCY - 1);
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_err   <= w_err;
            r_rdata <= (!r_write && !w_err) ? w_load : '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: store/load round trips, sign/zero
// extension, error responses, backpressure and reset during WAIT.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " req_ready"},  64'(bus.req_ready),  64'd1);
    chk({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, " resp_rdata"}, bus.resp_rdata,      64'd0);
    chk({tag, " resp_err"},   64'(bus.resp_err),   64'd0);
  endtask

  // One full transaction; request fields are scrambled right after the accept
  // edge so the response must come from the latched copy.
  task automatic txn(input string tag, input logic w, input logic [1:0] sz,
                     input logic u, input logic [63:0] a, input logic [63:0] d,
                     input int hold, output logic [63:0] rd, output logic er);
    int cyc;
    @(negedge clk);
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_valid    = 1'b1;
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_write    = ~w;
    bus.req_size     = ~sz;
    bus.req_unsigned = ~u;
    bus.req_addr     = ~a;
    bus.req_wdata    = ~d;
    cyc = 0;
    while (!bus.resp_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(LAT));
    rd = bus.resp_rdata;
    er = bus.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold valid"},     64'(bus.resp_valid), 64'd1);
      chk({tag, " hold rdata"},     bus.resp_rdata,      rd);
      chk({tag, " hold req_ready"}, 64'(bus.req_ready),  64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    idle_outputs({tag, " post"});
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] exp_d,
                          input logic exp_e);
    logic [63:0] rd;
    logic        er;
    txn(tag, 1'b0, sz, u, a, 64'hDEAD_BEEF_DEAD_BEEF, 0, rd, er);
    chk({tag, " rdata"}, rd, exp_d);
    chk({tag, " err"},   64'(er), 64'(exp_e));
  endtask

  task automatic store_chk(input string tag, input logic [1:0] sz,
                           input logic [63:0] a, input logic [63:0] d,
                           input logic exp_e);
    logic [63:0] rd;
    logic        er;
    txn(tag, 1'b1, sz, 1'b0, a, d, 0, rd, er);
    chk({tag, " rdata"}, rd, 64'd0);
    chk({tag, " err"},   64'(er), 64'(exp_e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;

    // Reset with a request asserted: it must be ignored.
    @(negedge clk);
    bus.req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_outputs("reset");
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_outputs("idle");

    // Double round trip.
    store_chk("st_d10", 2'b11, 64'h10, 64'h1122_3344_5566_7788, 1'b0);
    load_chk ("ld_d10", 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 1'b0);

    // Byte store and extensions.
    store_chk("st_b13", 2'b00, 64'h13, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    load_chk ("ld_b13s", 2'b00, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    load_chk ("ld_b13u", 2'b00, 1'b1, 64'h13, 64'h0000_0000_0000_0080, 1'b0);
    load_chk ("ld_d10b", 2'b11, 1'b0, 64'h10, 64'h1122_3344_8066_7788, 1'b0);
    load_chk ("ld_h12s", 2'b01, 1'b0, 64'h12, 64'hFFFF_FFFF_FFFF_8066, 1'b0);
    load_chk ("ld_w14u", 2'b10, 1'b1, 64'h14, 64'h0000_0000_1122_3344, 1'b0);
    load_chk ("ld_w10s", 2'b10, 1'b0, 64'h10, 64'hFFFF_FFFF_8066_7788, 1'b0);

    // Error cases, storage must stay unchanged.
    load_chk ("ld_w16mis", 2'b10, 1'b0, 64'h16, 64'd0, 1'b1);
    store_chk("st_w12mis", 2'b10, 64'h12, 64'h0000_0000_CAFE_F00D, 1'b1);
    store_chk("st_h11mis", 2'b01, 64'h11, 64'h0000_0000_0000_BEEF, 1'b1);
    load_chk ("ld_d10c", 2'b11, 1'b0, 64'h10, 64'h1122_3344_8066_7788, 1'b0);
    store_chk("st_d00", 2'b11, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
    load_chk ("ld_oor", 2'b11, 1'b0, 64'(DEPTH * 8), 64'd0, 1'b1);
    store_chk("st_oor", 2'b11, 64'(DEPTH * 8), 64'hFFFF_0000_FFFF_0000, 1'b1);
    load_chk ("ld_d00", 2'b11, 1'b0, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

    // Half store in the upper lanes, unsigned half readback.
    store_chk("st_h16", 2'b01, 64'h16, 64'h0000_0000_0000_BEEF, 1'b0);
    load_chk ("ld_d10d", 2'b11, 1'b0, 64'h10, 64'hBEEF_3344_8066_7788, 1'b0);
    load_chk ("ld_h16u", 2'b01, 1'b1, 64'h16, 64'h0000_0000_0000_BEEF, 1'b0);

    // Backpressure: response held for 5 cycles.
    txn("bp", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 5, rd, er);
    chk("bp rdata", rd, 64'hBEEF_3344_8066_7788);
    chk("bp err",   64'(er), 64'd0);

    // Reset during WAIT drops a pending store.
    store_chk("st_d20", 2'b11, 64'h20, 64'h0123_4567_89AB_CDEF, 1'b0);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 64'h20; bus.req_wdata = 64'hAA; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rstwait in_wait", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    idle_outputs("rstwait during");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_outputs("rstwait after");
    repeat (3) @(posedge clk);
    #1;
    chk("rstwait no_resp", 64'(bus.resp_valid), 64'd0);
    load_chk("ld_d20", 2'b11, 1'b0, 64'h20, 64'h0123_4567_89AB_CDEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
